control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL provide clr, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL provide IR, input, 32, instruction register contents; opcode = IR[31:27].
REQ-004 SHALL provide Gra, Grb, Grc, outputs, 1 each, register-field select strobes to the select/encode logic.
REQ-005 SHALL provide Rin, Rout, BAout, Cout, outputs, 1 each, general register load, register drive, base-address drive and sign-extended constant drive.
REQ-006 SHALL provide PCout, PCin, IncPC, IRin, Yin, outputs, 1 each, datapath register drive/load strobes.
REQ-007 SHALL provide MARin, MDRin, MDRout, Read, Write, outputs, 1 each, memory-path strobes.
REQ-008 SHALL provide ZLOen, ZHIen, ZLOout, outputs, 1 each; ZLOen and ZHIen always equal (Zin).
REQ-009 SHALL provide alu_control, output, 5, ALU operation code.
REQ-010 SHALL provide Run, output, 1, high while the sequencer is executing.

Function
REQ-011 States SHALL be RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT; one state per clock; all outputs Moore-decoded from state and IR only.
REQ-012 Opcodes SHALL be: 00000 ld, 00010 st, 00011 add, 00100 sub, 00101 and, 00110 or, 01100 addi, 01101 andi, 01110 ori, 11010 nop, 11011 halt; any other opcode executes as nop.
REQ-013 alu_control SHALL be: 00011 for add, addi, ld, st address calculation; 00100 sub; 00101 and/andi; 00110 or/ori; 10111 (increment) in T0; 00000 in all other states.
REQ-014 Fetch: T0 = PCout, MARin, IncPC, Zin; T1 = ZLOout, PCin, Read, MDRin; T2 = MDRout, IRin; T2 -> T3.
REQ-015 add/sub/and/or: T3 = Grb, Rout, Yin; T4 = Grc, Rout, Zin; T5 = ZLOout, Gra, Rin; T5 -> T0.
REQ-016 addi/andi/ori: T3 = Grb, Rout, Yin; T4 = Cout, Zin; T5 = ZLOout, Gra, Rin; T5 -> T0.
REQ-017 ld: T3 = Grb, BAout, Yin; T4 = Cout, Zin; T5 = ZLOout, MARin; T6 = Read, MDRin; T7 = MDRout, Gra, Rin; T7 -> T0.
REQ-018 st: T3 = Grb, BAout, Yin; T4 = Cout, Zin; T5 = ZLOout, MARin; T6 = Gra, Rout, MDRin; T7 = Write; T7 -> T0.
REQ-019 nop/unknown: T3 with all strobes low; T3 -> T0.
REQ-020 halt: T3 with all strobes low; T3 -> HALT; HALT holds until clr.
REQ-021 Opcode SHALL be sampled from IR in every state T3..T7 (IR is stable; IRin only asserted in T2).
REQ-022 Every strobe not listed for a state SHALL be 0 in that state; never more than one bus driver (Rout, BAout, Cout, PCout, MDRout, ZLOout) high per state.
REQ-023 Run SHALL be 1 in T0..T7, 0 in RST and HALT.

Reset
REQ-024 clr high SHALL force state RST immediately, from any state including mid-instruction, and drive all outputs 0.
REQ-025 First rising clk with clr low SHALL move RST -> T0; no partially executed instruction resumes.

Verification
REQ-026 Reset: assert clr during T4 of add -> all outputs 0, Run=0 same cycle; release -> next edge T0 with PCout=MARin=IncPC=ZLOen=1, alu_control=10111.
REQ-027 add: IR=0x18000000 (opcode 00011) -> 6 cycles T0..T5; T4 has Grc=Rout=ZLOen=ZHIen=1, alu_control=00011; T5 has ZLOout=Gra=Rin=1; then T0.
REQ-028 ld: IR opcode 00000 -> 8 cycles; T3 BAout=1 (not Rout); T6 Read=MDRin=1; T7 MDRout=Gra=Rin=1.
REQ-029 st: opcode 00010 -> T6 Gra=Rout=MDRin=1, Read=0; T7 Write=1 only; then T0.
REQ-030 halt: opcode 11011 -> after T3, Run=0 and HALT held for 20 cycles with all strobes 0; unknown opcode 11111 -> T3 then T0, Run stays 1.
REQ-031 Bench SHALL check REQ-022 bus-driver exclusivity every cycle across all scenarios.

Source files
------------

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore control sequencer for fetch/decode/execute of a small load/store ISA
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   clr          asynchronous active-high reset, forces RST and all outputs low
//   IR           instruction register contents, opcode in IR[31:27]
//   Gra/Grb/Grc  register-field select strobes
//   Rin/Rout     general register load / drive
//   BAout/Cout   base-address drive / sign-extended constant drive
//   PCout/PCin/IncPC/IRin/Yin                datapath register strobes
//   MARin/MDRin/MDRout/Read/Write            memory-path strobes
//   ZLOen/ZHIen  Z register load enables (both follow the internal Zin)
//   ZLOout       Z low-half drive
//   alu_control  ALU operation code
//   Run          high while an instruction is being sequenced (T0..T7)

module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        IRin,
    output logic        Yin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        ZLOen,
    output logic        ZHIen,
    output logic        ZLOout,
    output logic [4:0]  alu_control,
    output logic        Run
);

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] opcode;
    logic       op_rr;
    logic       op_ri;
    logic       op_ld;
    logic       op_st;
    logic       op_halt;
    logic [4:0] alu_op;
    logic       zin;
    logic       unused_ir_fields;

    assign opcode           = IR[31:27];
    // Register fields are decoded by the select/encode logic, not here.
    assign unused_ir_fields = ^IR[26:0];

    // Opcode classes; anything unrecognised falls through as a nop.
    always_comb begin
        op_rr   = 1'b0;
        op_ri   = 1'b0;
        op_ld   = 1'b0;
        op_st   = 1'b0;
        op_halt = 1'b0;
        alu_op  = 5'b00000;
        case (opcode)
            5'b00000: begin op_ld = 1'b1; alu_op = 5'b00011; end
            5'b00010: begin op_st = 1'b1; alu_op = 5'b00011; end
            5'b00011: begin op_rr = 1'b1; alu_op = 5'b00011; end
            5'b00100: begin op_rr = 1'b1; alu_op = 5'b00100; end
            5'b00101: begin op_rr = 1'b1; alu_op = 5'b00101; end
            5'b00110: begin op_rr = 1'b1; alu_op = 5'b00110; end
            5'b01100: begin op_ri = 1'b1; alu_op = 5'b00011; end
            5'b01101: begin op_ri = 1'b1; alu_op = 5'b00101; end
            5'b01110: begin op_ri = 1'b1; alu_op = 5'b00110; end
            5'b11011: op_halt = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        Rin         = 1'b0;
        Rout        = 1'b0;
        BAout       = 1'b0;
        Cout        = 1'b0;
        PCout       = 1'b0;
        PCin        = 1'b0;
        IncPC       = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        Read        = 1'b0;
        Write       = 1'b0;
        ZLOout      = 1'b0;
        zin         = 1'b0;
        alu_control = 5'b00000;
        case (state)
            RST: state_next = T0;
            T0: begin
                PCout       = 1'b1;
                MARin       = 1'b1;
                IncPC       = 1'b1;
                zin         = 1'b1;
                alu_control = 5'b10111;
                state_next  = T1;
            end
            T1: begin
                ZLOout     = 1'b1;
                PCin       = 1'b1;
                Read       = 1'b1;
                MDRin      = 1'b1;
                state_next = T2;
            end
            T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = T3;
            end
            T3: begin
                if (op_rr || op_ri) begin
                    Grb        = 1'b1;
                    Rout       = 1'b1;
                    Yin        = 1'b1;
                    state_next = T4;
                end else if (op_ld || op_st) begin
                    Grb        = 1'b1;
                    BAout      = 1'b1;
                    Yin        = 1'b1;
                    state_next = T4;
                end else if (op_halt) begin
                    state_next = HALT;
                end else begin
                    state_next = T0;
                end
            end
            T4: begin
                state_next = T0;
                if (op_rr) begin
                    Grc         = 1'b1;
                    Rout        = 1'b1;
                    zin         = 1'b1;
                    alu_control = alu_op;
                    state_next  = T5;
                end else if (op_ri || op_ld || op_st) begin
                    Cout        = 1'b1;
                    zin         = 1'b1;
                    alu_control = alu_op;
                    state_next  = T5;
                end
            end
            T5: begin
                state_next = T0;
                if (op_ld || op_st) begin
                    ZLOout     = 1'b1;
                    MARin      = 1'b1;
                    state_next = T6;
                end else if (op_rr || op_ri) begin
                    ZLOout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end
            end
            T6: begin
                state_next = T0;
                if (op_ld) begin
                    Read       = 1'b1;
                    MDRin      = 1'b1;
                    state_next = T7;
                end else if (op_st) begin
                    Gra        = 1'b1;
                    Rout       = 1'b1;
                    MDRin      = 1'b1;
                    state_next = T7;
                end
            end
            T7: begin
                state_next = T0;
                if (op_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (op_st) begin
                    Write = 1'b1;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RST;
        endcase
    end

    assign ZLOen = zin;
    assign ZHIen = zin;
    assign Run   = (state != RST) && (state != HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer against a micro-sequence model
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] IR  = 32'h18000000;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, IRin, Yin;
    logic MARin, MDRin, MDRout, Read, Write, ZLOen, ZHIen, ZLOout, Run;
    logic [4:0] alu_control;

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Cout(Cout), .PCout(PCout), .PCin(PCin),
        .IncPC(IncPC), .IRin(IRin), .Yin(Yin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
        .ZLOen(ZLOen), .ZHIen(ZHIen), .ZLOout(ZLOout),
        .alu_control(alu_control), .Run(Run)
    );

    always #5 clk = ~clk;

    // Output vector layout: {alu[4:0], Run, 20 strobes}
    localparam logic [25:0] GRA    = 26'h0000001;
    localparam logic [25:0] GRB    = 26'h0000002;
    localparam logic [25:0] GRC    = 26'h0000004;
    localparam logic [25:0] RIN    = 26'h0000008;
    localparam logic [25:0] ROUT   = 26'h0000010;
    localparam logic [25:0] BAOUT  = 26'h0000020;
    localparam logic [25:0] COUT   = 26'h0000040;
    localparam logic [25:0] PCOUT  = 26'h0000080;
    localparam logic [25:0] PCIN   = 26'h0000100;
    localparam logic [25:0] INCPC  = 26'h0000200;
    localparam logic [25:0] IRIN   = 26'h0000400;
    localparam logic [25:0] YIN    = 26'h0000800;
    localparam logic [25:0] MARIN  = 26'h0001000;
    localparam logic [25:0] MDRIN  = 26'h0002000;
    localparam logic [25:0] MDROUT = 26'h0004000;
    localparam logic [25:0] READ   = 26'h0008000;
    localparam logic [25:0] WRITE  = 26'h0010000;
    localparam logic [25:0] ZIN    = 26'h0060000;
    localparam logic [25:0] ZLOOUT = 26'h0080000;
    localparam logic [25:0] RUN    = 26'h0100000;

    logic [25:0] obs;
    assign obs = {alu_control, Run, ZLOout, ZHIen, ZLOen, Write, Read, MDRout,
                  MDRin, MARin, Yin, IRin, IncPC, PCin, PCout, Cout, BAout,
                  Rout, Rin, Grc, Grb, Gra};

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [25:0] aluv(input logic [4:0] a);
        return {a, 21'b0};
    endfunction

    // ALU code used in the operand-combine step of each instruction
    function automatic logic [4:0] alu_for(input logic [4:0] op);
        case (op)
            5'b00100:          return 5'b00100;
            5'b00101, 5'b01101: return 5'b00101;
            5'b00110, 5'b01110: return 5'b00110;
            default:           return 5'b00011;
        endcase
    endfunction

    // Model: a queue of the remaining micro-steps of the current instruction
    logic [25:0] mdl_q[$];
    logic [25:0] mdl_cur     = 26'h0;
    bit          mdl_in_rst  = 1'b1;
    bit          need_decode = 1'b0;
    bit          halt_after  = 1'b0;
    bit          halted      = 1'b0;

    task automatic push_tail(input logic [4:0] op);
        logic [25:0] a;
        a = aluv(alu_for(op));
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                mdl_q.push_back(RUN | GRB | ROUT | YIN);
                mdl_q.push_back(RUN | GRC | ROUT | ZIN | a);
                mdl_q.push_back(RUN | ZLOOUT | GRA | RIN);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                mdl_q.push_back(RUN | GRB | ROUT | YIN);
                mdl_q.push_back(RUN | COUT | ZIN | a);
                mdl_q.push_back(RUN | ZLOOUT | GRA | RIN);
            end
            5'b00000: begin
                mdl_q.push_back(RUN | GRB | BAOUT | YIN);
                mdl_q.push_back(RUN | COUT | ZIN | a);
                mdl_q.push_back(RUN | ZLOOUT | MARIN);
                mdl_q.push_back(RUN | READ | MDRIN);
                mdl_q.push_back(RUN | MDROUT | GRA | RIN);
            end
            5'b00010: begin
                mdl_q.push_back(RUN | GRB | BAOUT | YIN);
                mdl_q.push_back(RUN | COUT | ZIN | a);
                mdl_q.push_back(RUN | ZLOOUT | MARIN);
                mdl_q.push_back(RUN | GRA | ROUT | MDRIN);
                mdl_q.push_back(RUN | WRITE);
            end
            5'b11011: begin
                mdl_q.push_back(RUN);
                halt_after = 1'b1;
            end
            default: mdl_q.push_back(RUN);
        endcase
    endtask

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mdl_q.delete();
            mdl_cur     = 26'h0;
            mdl_in_rst  = 1'b1;
            need_decode = 1'b0;
            halt_after  = 1'b0;
            halted      = 1'b0;
        end else if (!halted) begin
            if (mdl_q.size() == 0) begin
                if (need_decode) begin
                    push_tail(IR[31:27]);
                    need_decode = 1'b0;
                end else if (halt_after && !mdl_in_rst) begin
                    halted = 1'b1;
                end else begin
                    mdl_q.push_back(RUN | PCOUT | MARIN | INCPC | ZIN | aluv(5'b10111));
                    mdl_q.push_back(RUN | ZLOOUT | PCIN | READ | MDRIN);
                    mdl_q.push_back(RUN | MDROUT | IRIN);
                    need_decode = 1'b1;
                end
            end
            mdl_in_rst = 1'b0;
            mdl_cur    = halted ? 26'h0 : mdl_q.pop_front();
        end
    end

    // Compare process: model vs DUT and bus-driver exclusivity on every cycle
    always @(negedge clk) begin
        chk("model", {6'b0, obs}, {6'b0, mdl_cur});
        chk("bus_excl", {31'b0, (32'(Rout) + 32'(BAout) + 32'(Cout) + 32'(PCout)
                                 + 32'(MDRout) + 32'(ZLOout)) <= 32'd1}, 32'd1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset, load IR, release; the next negedge then shows T0
    task automatic start(input logic [31:0] ir);
        clr = 1'b1;
        step(2);
        IR  = ir;
        clr = 1'b0;
    endtask

    initial begin
        step(1);
        chk("rst_run", {31'b0, Run}, 32'd0);
        chk("rst_outs", {6'b0, obs}, 32'd0);

        // add, followed by a second add cut short by clr in T4
        start(32'h18000000);
        step(1);
        chk("t0_vec", {6'b0, obs}, 32'h02F61280);
        step(4);
        chk("add_t4_grc", {31'b0, Grc}, 32'd1);
        chk("add_t4_rout", {31'b0, Rout}, 32'd1);
        chk("add_t4_zen", {30'b0, ZLOen, ZHIen}, 32'd3);
        chk("add_t4_alu", {27'b0, alu_control}, 32'h03);
        step(1);
        chk("add_t5", {6'b0, obs}, 32'h0010_0009 | 32'h80000);
        step(1);
        chk("add_next_t0", {31'b0, PCout}, 32'd1);
        step(4);
        #1 clr = 1'b1;
        #1;
        chk("clr_mid_outs", {6'b0, obs}, 32'd0);
        chk("clr_mid_run", {31'b0, Run}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        step(1);
        chk("post_clr_t0", {27'b0, PCout, MARin, IncPC, ZLOen, Run}, 32'h1F);
        chk("post_clr_alu", {27'b0, alu_control}, 32'h17);

        // ld
        start(32'h01234567);
        step(4);
        chk("ld_t3_ba", {30'b0, BAout, Rout}, 32'd2);
        step(3);
        chk("ld_t6", {30'b0, Read, MDRin}, 32'd3);
        step(1);
        chk("ld_t7", {29'b0, MDRout, Gra, Rin}, 32'd7);
        step(1);
        chk("ld_after_t0", {31'b0, PCout}, 32'd1);

        // st
        start(32'h10000000);
        step(7);
        chk("st_t6", {28'b0, Gra, Rout, MDRin, Read}, 32'hE);
        step(1);
        chk("st_t7", {6'b0, obs}, 32'h00110000);
        step(1);
        chk("st_after_t0", {31'b0, PCout}, 32'd1);

        // remaining ALU forms, checked by the model through two instructions each
        start(32'h20000000); step(5); chk("sub_alu", {27'b0, alu_control}, 32'h04); step(7);
        start(32'h28000000); step(12);
        start(32'h30000000); step(12);
        start(32'h60000000); step(5); chk("addi_cout", {31'b0, Cout}, 32'd1); step(7);
        start(32'h68000000); step(5); chk("andi_alu", {27'b0, alu_control}, 32'h05); step(7);
        start(32'h70000000); step(12);
        start(32'hD0000000); step(10);

        // unknown opcode behaves as nop
        start(32'hF8000000);
        step(4);
        chk("unk_t3", {6'b0, obs}, 32'h00100000);
        step(1);
        chk("unk_t0", {31'b0, PCout}, 32'd1);
        chk("unk_run", {31'b0, Run}, 32'd1);

        // halt
        start(32'hD8000000);
        step(4);
        chk("halt_t3_run", {31'b0, Run}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("halt_held", {6'b0, obs}, 32'd0);
        end
        start(32'h18000000);
        step(1);
        chk("halt_clr_t0", {31'b0, PCout}, 32'd1);
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
